// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional header feature: UART_ARB_HDR_EN.
package uart_arb_pkg;

   // Arbiter states; HDR is only reachable when UART_ARB_HDR_EN is defined.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      XFER = 2'd2
   } arb_state_t;

   // Upper nibble of the header byte announcing the granted requester.
   localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin winner search: the first requesting index at or after
// (last_winner + 1) mod N, wrapping around the vector.
module rr_arbiter_n #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_winner,
   output logic [$clog2(N)-1:0] winner,
   output logic                 found
);

   localparam int IW = $clog2(N);

   int cand;

   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = 0;
      for (int off = N; off >= 1; off--) begin
         cand = (int'(last_winner) + off) % N;
         if (req[cand]) begin
            winner = IW'(cand);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N byte-stream requesters onto a single UART transmitter.
// A grant lasts until the requester's last byte or MAX_LEN bytes, whichever
// comes first; a MAX_LEN cut-off pulses abort_o and rotates the priority.
// Optional feature macro: UART_ARB_HDR_EN inserts a header byte
// {HDR_TAG, winner index} ahead of each granted packet.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int n       = 8,
   parameter int MAX_LEN = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req_valid_i,
   input  logic [n-1:0] req_data_i [0:N-1],
   input  logic [N-1:0] req_last_i,
   output logic [N-1:0] req_ready_o,
   output logic [n-1:0] tx_data_o,
   output logic         tx_valid_o,
   input  logic         tx_ready_i,
   output logic [N-1:0] gnt_o,
   output logic         busy_o,
   output logic         abort_o
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);

   arb_state_t    state_reg, state_next;
   logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
   logic [IW-1:0] last_winner_reg, last_winner_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [IW-1:0] arb_winner;
   logic          arb_found;

   rr_arbiter_n #(
      .N (N)
   ) u_rr (
      .req         (req_valid_i),
      .last_winner (last_winner_reg),
      .winner      (arb_winner),
      .found       (arb_found)
   );

   assign busy_o = (state_reg != IDLE);
   assign gnt_o  = (state_reg == IDLE) ? '0 : (N'(1) << gnt_idx_reg);

   // State, grant index, priority pointer and byte counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg       <= IDLE;
         gnt_idx_reg     <= '0;
         last_winner_reg <= IW'(N - 1);
         cnt_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         gnt_idx_reg     <= gnt_idx_next;
         last_winner_reg <= last_winner_next;
         cnt_reg         <= cnt_next;
      end
   end

   // Next-state logic plus the combinational pass-through of the granted lane.
   always_comb begin
      state_next       = state_reg;
      gnt_idx_next     = gnt_idx_reg;
      last_winner_next = last_winner_reg;
      cnt_next         = cnt_reg;
      tx_valid_o       = 1'b0;
      tx_data_o        = '0;
      req_ready_o      = '0;
      abort_o          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arb_found) begin
               gnt_idx_next = arb_winner;
               cnt_next     = '0;
`ifdef UART_ARB_HDR_EN
               state_next   = HDR;
`else
               state_next   = XFER;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = {HDR_TAG, (n - 4)'(gnt_idx_reg)};
            if (tx_ready_i) begin
               state_next = XFER;
            end
         end
`endif
         XFER: begin
            tx_valid_o               = req_valid_i[gnt_idx_reg];
            tx_data_o                = req_data_i[gnt_idx_reg];
            req_ready_o[gnt_idx_reg] = tx_ready_i;
            if (req_valid_i[gnt_idx_reg] && tx_ready_i) begin
               if (req_last_i[gnt_idx_reg]) begin
                  state_next       = IDLE;
                  last_winner_next = gnt_idx_reg;
                  cnt_next         = '0;
               end else if (cnt_reg == CNT_LAST) begin
                  // Length limit hit without last: release and rotate priority.
                  state_next       = IDLE;
                  last_winner_next = gnt_idx_reg;
                  cnt_next         = '0;
                  abort_o          = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
